// File: rtl/mii_rx_capture.sv
// MII receive frame capture: strips preamble/SFD, grabs a window of post-SFD
// nibbles from each good frame and keeps good/error frame statistics.
module mii_rx_capture #(
  parameter int CAPTURE_NIBBLES = 8,
  parameter int OFFSET_W        = 16,
  parameter int MIN_PREAMBLE    = 2
) (
  input  logic                         enet_rx_clk,
  input  logic                         i_nreset,
  input  logic                         enet_rx_dv,
  input  logic [3:0]                   enet_rx_data,
  input  logic [OFFSET_W-1:0]          i_capture_offset,
  input  logic                         i_clear,
  output logic [4*CAPTURE_NIBBLES-1:0] o_capture,
  output logic                         o_capture_valid,
  output logic [31:0]                  o_frame_count,
  output logic [15:0]                  o_err_count,
  output logic [OFFSET_W-1:0]          o_last_len,
  output logic                         o_busy
);

  localparam int                CAP_W    = 4 * CAPTURE_NIBBLES;
  localparam logic [4:0]        MIN_PRE  = 5'(MIN_PREAMBLE);
  localparam logic [OFFSET_W:0] WIN_SPAN = (OFFSET_W + 1)'(CAPTURE_NIBBLES);
  localparam logic [3:0]        NIB_PRE  = 4'h5;
  localparam logic [3:0]        NIB_SFD  = 4'hD;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          pre_cnt;
  logic [OFFSET_W-1:0] idx;
  logic [OFFSET_W-1:0] offset_q;
  logic [CAP_W-1:0]    working;
  logic [CAP_W-1:0]    working_shift;
  logic                is_pre, sfd_ok, in_window;
  logic                sfd_hit, frame_good, frame_err;

  assign is_pre = (enet_rx_data == NIB_PRE);
  assign sfd_ok = (enet_rx_data == NIB_SFD) && ({1'b0, pre_cnt} >= MIN_PRE);

  // Window end is computed one bit wider so offsets near all-ones cannot wrap.
  assign in_window = (idx >= offset_q) &&
                     ({1'b0, idx} < ({1'b0, offset_q} + WIN_SPAN));

  generate
    if (CAPTURE_NIBBLES == 1) begin : g_shift_one
      assign working_shift = enet_rx_data;
    end else begin : g_shift_many
      assign working_shift = {working[CAP_W-5:0], enet_rx_data};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge enet_rx_clk or negedge i_nreset) begin
    if (!i_nreset) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: defaulting every combinational output first prevents latch inference.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enet_rx_dv) state_nxt = is_pre ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!enet_rx_dv)     state_nxt = IDLE;
        else if (is_pre)     state_nxt = PREAMBLE;
        else if (sfd_ok)     state_nxt = DATA;
        else                 state_nxt = DROP;
      end
      DATA:     if (!enet_rx_dv) state_nxt = IDLE;
      DROP:     if (!enet_rx_dv) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != IDLE);
    sfd_hit    = (state == PREAMBLE) && enet_rx_dv && !is_pre && sfd_ok;
    frame_good = (state == DATA) && !enet_rx_dv && !idx[0];
    frame_err  = !enet_rx_dv &&
                 ((state == PREAMBLE) || (state == DROP) ||
                  ((state == DATA) && idx[0]));
  end

  // NOTE: working/idx are plain registers, so they take the async reset too;
  // leaving them unreset would let X leak into o_capture after power-up.
  always_ff @(posedge enet_rx_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      pre_cnt  <= '0;
      idx      <= '0;
      offset_q <= '0;
      working  <= '0;
    end else begin
      if (state == IDLE && enet_rx_dv && is_pre)
        pre_cnt <= 4'd1;
      else if (state == PREAMBLE && enet_rx_dv && is_pre && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (sfd_hit) begin
        idx      <= '0;
        working  <= '0;
        offset_q <= i_capture_offset;
      end else if (state == DATA && enet_rx_dv) begin
        if (idx != '1) idx <= idx + OFFSET_W'(1);
        if (in_window) working <= working_shift;
      end
    end
  end

  always_ff @(posedge enet_rx_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      o_capture       <= '0;
      o_capture_valid <= 1'b0;
      o_last_len      <= '0;
      o_frame_count   <= '0;
      o_err_count     <= '0;
    end else begin
      o_capture_valid <= frame_good;
      if (frame_good) begin
        o_capture  <= working;
        o_last_len <= idx >> 1;
      end

      // Clear wins over any increment landing on the same edge.
      if (i_clear) begin
        o_frame_count <= '0;
        o_err_count   <= '0;
      end else begin
        if (frame_good)                     o_frame_count <= o_frame_count + 32'd1;
        if (frame_err && o_err_count != '1) o_err_count   <= o_err_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/mii_rx_capture.md
MII_RX_CAPTURE -- requirements
Module: mii_rx_capture

Interface
REQ-001 SHALL have parameter CAPTURE_NIBBLES, default 8 (range 1..16): number of nibbles held in the capture window.
REQ-002 SHALL have parameter OFFSET_W, default 16: width of the capture-offset input and of the per-frame nibble counter.
REQ-003 SHALL have parameter MIN_PREAMBLE, default 2: minimum count of 0x5 nibbles required before SFD.
REQ-004 SHALL have port enet_rx_clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_nreset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enet_rx_dv, input, 1: MII receive data valid.
REQ-007 SHALL have port enet_rx_data, input, 4: MII receive nibble, low nibble of each byte first.
REQ-008 SHALL have port i_capture_offset, input, OFFSET_W: index of the first post-SFD nibble to capture.
REQ-009 SHALL have port i_clear, input, 1: synchronous clear of the counters.
REQ-010 SHALL have port o_capture, output, 4*CAPTURE_NIBBLES: captured window from the last good frame.
REQ-011 SHALL have port o_capture_valid, output, 1: one-cycle pulse when o_capture updates.
REQ-012 SHALL have port o_frame_count, output, 32: good frames received.
REQ-013 SHALL have port o_err_count, output, 16: dropped or odd-length frames.
REQ-014 SHALL have port o_last_len, output, OFFSET_W: byte length of the last good frame.
REQ-015 SHALL have port o_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, PREAMBLE, DATA and DROP.
REQ-017 IDLE: on dv=1 with nibble 0x5, SHALL go to PREAMBLE with preamble count = 1; on dv=1 with any other nibble, SHALL go to DROP.
REQ-018 PREAMBLE, dv=1, nibble 0x5: SHALL increment the preamble count, saturating at 15.
REQ-019 PREAMBLE, dv=1, nibble 0xD with preamble count >= MIN_PREAMBLE: SHALL go to DATA, clear the nibble index and working register to 0, and sample i_capture_offset.
REQ-020 PREAMBLE, dv=1, nibble 0xD with preamble count < MIN_PREAMBLE, or any other nibble: SHALL go to DROP.
REQ-021 PREAMBLE, dv=0: SHALL go to IDLE and increment o_err_count.
REQ-022 DATA, dv=1: SHALL increment the nibble index idx, saturating at all-ones.
REQ-023 DATA, dv=1: when sampled_offset <= idx < sampled_offset+CAPTURE_NIBBLES, SHALL update working <= {working[4N-5:0], nibble}.
REQ-024 DATA, dv=1: outside that window, working SHALL hold.
REQ-025 DATA, dv=0, idx even: SHALL update o_capture <= working, set o_last_len = idx/2, increment o_frame_count (wrapping), pulse o_capture_valid in the next cycle only, and go to IDLE.
REQ-026 DATA, dv=0, idx odd (dribble): SHALL increment o_err_count, leave o_capture, o_last_len and o_frame_count unchanged, and go to IDLE.
REQ-027 DROP: SHALL remain in DROP while dv=1; on dv=0 SHALL increment o_err_count and go to IDLE.
REQ-028 Frames shorter than the window end SHALL leave unfilled upper nibbles of o_capture at 0.
REQ-029 o_err_count SHALL saturate at 0xFFFF.
REQ-030 The window-end comparison SHALL use OFFSET_W+1 bits, so no wrap occurs for large offsets.
REQ-031 i_clear SHALL zero o_frame_count and o_err_count, taking priority over a simultaneous increment.
REQ-032 i_clear SHALL NOT affect the FSM, o_capture or o_last_len.
REQ-033 A change of i_capture_offset during DATA SHALL have no effect until the next SFD.

Reset
REQ-034 While i_nreset=0, SHALL asynchronously force the state to IDLE and set o_capture, o_frame_count, o_err_count, o_last_len, o_capture_valid, working, idx and preamble count to 0.
REQ-035 On reset assertion mid-frame, the partial frame SHALL be discarded with no counter update.
REQ-036 After reset release with dv=1 mid-frame, SHALL treat the frame as a bad start: DROP, then o_err_count=1 once dv falls.

Verification
REQ-037 Case N=8, offset 0: 15x 0x5, 0xD, then 2,1,4,3,6,5,8,7, then dv=0 -> o_capture=0x21436587, o_last_len=4, o_frame_count=1, one-cycle o_capture_valid.
REQ-038 Same frame, offset 2 -> o_capture=0x00436587; offset 100 -> o_capture=0x00000000 with valid pulse and o_last_len=4.
REQ-039 Same preamble, 7 data nibbles -> o_err_count=1, o_frame_count=0, no valid pulse.
REQ-040 Frame starting 0x3 -> DROP for the whole frame, o_err_count=1; frame of 0x5, 0xD with MIN_PREAMBLE=2 -> DROP, o_err_count=1.
REQ-041 i_clear on the same cycle as a good frame end -> o_frame_count=0 and o_capture updated; i_nreset pulsed mid-DATA -> all outputs 0 and the next good frame gives o_frame_count=1.
REQ-042 Two back-to-back good frames with one dv=0 cycle between them -> o_frame_count=2 and two distinct valid pulses.
